// File: rtl/mac_port_reader.sv
// mac_port_reader: watches the producer's two registered result ports,
// turns every value change into a tagged FIFO entry, and hands entries out
// through a valid/ready read port. Keeps saturating per-port counters and
// tracks the producer phase: IDLE -> RUN on the first port_A update, and
// -> POST on the first port_B update.
//
// Optional feature: define MAC_READER_CHECK_EN to add a monotonic checker.
// It flags any accepted port value that is lower than the previously
// accepted value on the same port. With the macro undefined, mono_err is
// tied to 0 and the checker registers do not exist.
//
// Read handshake: rd_valid is high whenever the FIFO holds an entry, and
// rd_data/rd_src then show the head entry. An entry leaves at the rising edge
// where rd_valid && rd_ready. The head stays stable while rd_ready is low.
module mac_port_reader #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] port_A,
    input  logic [DW-1:0] port_B,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_src,
    output logic [7:0]    cnt_a,
    output logic [7:0]    cnt_b,
    output logic [1:0]    phase,
    output logic          overflow,
    output logic          mono_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        POST = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] prev_a;
    logic [DW-1:0] prev_b;
    logic [DW:0]   mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;

    logic          ev_a;
    logic          ev_b;
    logic [CW-1:0] free;
    logic          acc_a;
    logic          acc_b;
    logic          pop;
    logic [PW-1:0] slot_b;
    logic [DW:0]   head;

    // Event detection and admission. Free space comes from the registered
    // count only, so a same-cycle pop never makes room for this cycle's
    // pushes. B is dropped before A when space runs short.
    always_comb begin
        ev_a   = (port_A != prev_a);
        ev_b   = (port_B != prev_b);
        free   = CW'(DEPTH) - count;
        acc_a  = ev_a && (free >= CW'(1));
        acc_b  = ev_b && (free >= (acc_a ? CW'(2) : CW'(1)));
        pop    = rd_valid && rd_ready;
        slot_b = acc_a ? (wptr + PW'(1)) : wptr;
    end

    assign head     = mem[rptr];
    assign rd_valid = (count != '0);
    assign rd_data  = rd_valid ? head[DW-1:0] : '0;
    assign rd_src   = rd_valid & head[DW];
    assign phase    = state;

    // Entry storage. Only the pointers and count need a reset, because
    // outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (acc_a) mem[wptr]   <= {1'b0, port_A};
            if (acc_b) mem[slot_b] <= {1'b1, port_B};
        end
    end

    // Port history, FIFO pointers, occupancy, counters and the sticky
    // overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_a   <= '0;
            prev_b   <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            overflow <= 1'b0;
        end else begin
            prev_a <= port_A;
            prev_b <= port_B;
            wptr   <= wptr + PW'(acc_a) + PW'(acc_b);
            rptr   <= rptr + PW'(pop);
            count  <= count + CW'(acc_a) + CW'(acc_b) - CW'(pop);
            if (acc_a && cnt_a != 8'hFF) cnt_a <= cnt_a + 8'd1;
            if (acc_b && cnt_b != 8'hFF) cnt_b <= cnt_b + 8'd1;
            if ((ev_a && !acc_a) || (ev_b && !acc_b)) overflow <= 1'b1;
        end
    end

    // Producer phase tracker. POST is absorbing, and a simultaneous A+B
    // update from IDLE goes straight to POST.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (acc_b)      state <= POST;
                    else if (acc_a) state <= RUN;
                end
                RUN: begin
                    if (acc_b) state <= POST;
                end
                POST:    state <= POST;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MAC_READER_CHECK_EN
    logic [DW-1:0] last_a;
    logic [DW-1:0] last_b;
    logic          mono_q;

    // Monotonic checker: an accepted value below the last accepted value
    // on the same port is a violation.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_a <= '0;
            last_b <= '0;
            mono_q <= 1'b0;
        end else begin
            if (acc_a) begin
                last_a <= port_A;
                if (port_A < last_a) mono_q <= 1'b1;
            end
            if (acc_b) begin
                last_b <= port_B;
                if (port_B < last_b) mono_q <= 1'b1;
            end
        end
    end

    assign mono_err = mono_q;
`else
    assign mono_err = 1'b0;
`endif

endmodule

// File: tb/tb_mac_port_reader.sv
// Bench for mac_port_reader. Port changes are applied 1 ns after a rising
// edge. Expected entries go into exp_q when they are driven. A negedge
// monitor pops exp_q and compares the entry on every read handshake.
module tb_mac_port_reader;

    localparam int DEPTH = 4;
    localparam int DW    = 8;
`ifdef MAC_READER_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [DW-1:0] port_A;
    logic [DW-1:0] port_B;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_src;
    logic [7:0]    cnt_a;
    logic [7:0]    cnt_b;
    logic [1:0]    phase;
    logic          overflow;
    logic          mono_err;

    logic [DW:0]   exp_q[$];
    logic [DW-1:0] cur_a;
    logic [DW-1:0] cur_b;
    int            n_checks;
    int            n_errors;

    mac_port_reader #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .port_A   (port_A),
        .port_B   (port_B),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_src   (rd_src),
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b),
        .phase    (phase),
        .overflow (overflow),
        .mono_err (mono_err)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard monitor: every handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL pop_unexpected: got {%0d,%0d}, expected queue empty", rd_src, rd_data);
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                if ({rd_src, rd_data} !== e) begin
                    n_errors++;
                    $display("FAIL pop_entry: got {%0d,%0d}, expected {%0d,%0d}",
                             rd_src, rd_data, e[DW], e[DW-1:0]);
                end
            end
        end
    end

    // Driver: change ports just after an edge and predict the queued entries.
    // Occupancy at this point equals exp_q.size(), because the monitor has
    // already removed entries popped at the last edge.
    task automatic set_ports(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int free;
        bit ok_a;
        bit ok_b;
        @(posedge clk);
        #1;
        free = DEPTH - exp_q.size();
        ok_a = (a != cur_a) && (free >= 1);
        ok_b = (b != cur_b) && (free >= (ok_a ? 2 : 1));
        if (ok_a) exp_q.push_back({1'b0, a});
        if (ok_b) exp_q.push_back({1'b1, b});
        port_A = a;
        port_B = b;
        cur_a  = a;
        cur_b  = b;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        port_A   = '0;
        port_B   = '0;
        rd_ready = 1'b0;
        cur_a    = '0;
        cur_b    = '0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        port_A = '0;
        port_B = '0;
        rd_ready = 1'b0;
        cur_a = '0;
        cur_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({rd_valid, rd_data, rd_src, cnt_a, cnt_b, phase, overflow, mono_err} !== '0) begin
            n_errors++;
            $display("FAIL reset_values: valid=%0d data=%0d src=%0d cnt_a=%0d cnt_b=%0d phase=%0d ovf=%0d mono=%0d, expected all 0",
                     rd_valid, rd_data, rd_src, cnt_a, cnt_b, phase, overflow, mono_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({rd_valid, rd_data, rd_src, cnt_a, cnt_b, phase, overflow, mono_err} !== '0) begin
                n_errors++;
                $display("FAIL idle_after_reset cycle %0d: valid=%0d phase=%0d cnt_a=%0d ovf=%0d, expected all 0",
                         i, rd_valid, phase, cnt_a, overflow);
            end
        end
    endtask

    task automatic test_ramp();
        logic [DW-1:0] vals [3];
        vals[0] = 8'd10;
        vals[1] = 8'd16;
        vals[2] = 8'd23;
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_ports(vals[i], 8'd0);
            if (i > 0) begin
                n_checks++;
                if (!(rd_valid === 1'b1 && rd_data === vals[i-1] && rd_src === 1'b0)) begin
                    n_errors++;
                    $display("FAIL ramp_latency %0d: valid=%0d data=%0d src=%0d, expected 1/%0d/0",
                             i - 1, rd_valid, rd_data, rd_src, vals[i-1]);
                end
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (!(rd_valid === 1'b1 && rd_data === 8'd23 && rd_src === 1'b0)) begin
            n_errors++;
            $display("FAIL ramp_latency 2: valid=%0d data=%0d, expected 1/23", rd_valid, rd_data);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (cnt_a !== 8'd3 || phase !== 2'd1 || rd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL ramp_final: cnt_a=%0d phase=%0d valid=%0d, expected 3/1/0", cnt_a, phase, rd_valid);
        end
    endtask

    task automatic test_dual();
        do_reset();
        rd_ready = 1'b1;
        set_ports(8'd40, 8'd63);
        n_checks++;
        if (phase !== 2'd0) begin
            n_errors++;
            $display("FAIL dual_phase_before: phase=%0d, expected 0", phase);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (!(rd_valid === 1'b1 && rd_data === 8'd40 && rd_src === 1'b0 &&
              phase === 2'd2 && cnt_a === 8'd1 && cnt_b === 8'd1)) begin
            n_errors++;
            $display("FAIL dual_first: valid=%0d data=%0d src=%0d phase=%0d cnt_a=%0d cnt_b=%0d, expected 1/40/0/2/1/1",
                     rd_valid, rd_data, rd_src, phase, cnt_a, cnt_b);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (!(rd_valid === 1'b1 && rd_data === 8'd63 && rd_src === 1'b1)) begin
            n_errors++;
            $display("FAIL dual_second: valid=%0d data=%0d src=%0d, expected 1/63/1", rd_valid, rd_data, rd_src);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
        int cycles;
        do_reset();
        for (int i = 1; i <= 5; i++) set_ports(8'(i), 8'd0);
        @(posedge clk);
        #1;
        n_checks++;
        if (overflow !== 1'b1 || cnt_a !== 8'd4) begin
            n_errors++;
            $display("FAIL ovf_flags: overflow=%0d cnt_a=%0d, expected 1/4", overflow, cnt_a);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (!(rd_valid === 1'b1 && rd_data === 8'd1 && rd_src === 1'b0)) begin
                n_errors++;
                $display("FAIL ovf_stall_stable: valid=%0d data=%0d, expected 1/1", rd_valid, rd_data);
            end
        end
        @(posedge clk);
        #1;
        rd_ready = 1'b1;
        cycles = 0;
        while (rd_valid === 1'b1 && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        n_checks++;
        if (cycles != 4) begin
            n_errors++;
            $display("FAIL ovf_drain_cycles: took %0d cycles, expected 4", cycles);
        end
    endtask

    task automatic test_mono();
        do_reset();
        rd_ready = 1'b1;
        set_ports(8'd30, 8'd0);
        set_ports(8'd20, 8'd0);
        n_checks++;
        if (mono_err !== 1'b0) begin
            n_errors++;
            $display("FAIL mono_before: mono_err=%0d, expected 0", mono_err);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (mono_err !== CHECK_EN) begin
            n_errors++;
            $display("FAIL mono_edge: mono_err=%0d, expected %0d", mono_err, CHECK_EN);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (mono_err !== CHECK_EN) begin
            n_errors++;
            $display("FAIL mono_sticky: mono_err=%0d, expected %0d", mono_err, CHECK_EN);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_ports(8'd5, 8'd0);
        set_ports(8'd6, 8'd0);
        set_ports(8'd7, 8'd9);
        @(posedge clk);
        #1;
        n_checks++;
        if (!(rd_valid === 1'b1 && overflow === 1'b0 && cnt_a === 8'd3)) begin
            n_errors++;
            $display("FAIL mid_prefill: valid=%0d ovf=%0d cnt_a=%0d, expected 1/0/3", rd_valid, overflow, cnt_a);
        end
        // Reset cycle carrying a port_A change that must not be queued.
        set_ports(8'd8, 8'd9);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst    = 1'b0;
        port_A = '0;
        port_B = '0;
        cur_a  = '0;
        cur_b  = '0;
        n_checks++;
        if ({rd_valid, cnt_a, cnt_b, phase, overflow} !== '0) begin
            n_errors++;
            $display("FAIL mid_reset_state: valid=%0d cnt_a=%0d cnt_b=%0d phase=%0d ovf=%0d, expected all 0",
                     rd_valid, cnt_a, cnt_b, phase, overflow);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (rd_valid !== 1'b0 || cnt_a !== 8'd0) begin
            n_errors++;
            $display("FAIL mid_no_entry: valid=%0d cnt_a=%0d, expected 0/0", rd_valid, cnt_a);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_ramp();
        test_dual();
        test_overflow();
        test_mono();
        test_reset_mid();
        repeat (2) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_leftover: %0d entries never popped, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
